// File: rtl/hov_io_pkg.sv
// Shared I/O definitions for the HOV capture/stimulus blocks: default word
// and index widths, channel selector encoding and a depth helper.
package hov_io_pkg;

  localparam int HOV_DATA_W = 12;
  localparam int HOV_ADDR_W = 8;
  localparam int HOV_NUM_CH = 2;

  // Host readback channel selector.
  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } ch_sel_e;

  // Number of buffer entries addressed by an index of the given width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/output_channel.sv
// One capture channel: capture RAM, expected-value RAM, word counter and the
// full/overflow/mismatch status. The comparison against the expected word is
// done one cycle after acceptance, using the registered expected-RAM read
// taken in the accept cycle (so a same-cycle expected load is seen as old).
module output_channel
  import hov_io_pkg::*;
#(
  parameter int DATA_W = HOV_DATA_W,
  parameter int ADDR_W = HOV_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_exp_write,
  input  logic [ADDR_W-1:0] i_exp_addr,
  input  logic [DATA_W-1:0] i_exp_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_q,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_mismatch,
  output logic [ADDR_W-1:0] o_first_bad
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_cap_mem [DEPTH];
  logic [DATA_W-1:0] r_exp_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_q;
  logic [DATA_W-1:0] r_exp_q;

  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_mismatch;
  logic [ADDR_W-1:0] r_first_bad;

  logic              r_cmp_valid;
  logic [DATA_W-1:0] r_cmp_data;
  logic [ADDR_W-1:0] r_cmp_idx;

  logic              w_full;
  logic              w_accept;
  logic [ADDR_W-1:0] w_idx;
  logic              w_bad;

  // Count reaches DEPTH exactly when its top bit is set.
  assign w_full   = r_count[ADDR_W];
  assign w_accept = i_wr & ~w_full & ~rst;
  assign w_idx    = r_count[ADDR_W-1:0];
  assign w_bad    = r_cmp_valid & (r_cmp_data != r_exp_q);

  // Capture RAM: write accepted words, read-first registered host readback.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cap_mem[w_idx] <= i_wr_data;
    end
    r_rd_q <= r_cap_mem[i_rd_addr];
  end

  // Expected RAM: host loads (also during reset), read-first lookup at the
  // current capture index for the comparison stage.
  always_ff @(posedge clk) begin
    if (i_exp_write) begin
      r_exp_mem[i_exp_addr] <= i_exp_data;
    end
    r_exp_q <= r_exp_mem[w_idx];
  end

  // Comparison stage: hold the accepted word and its index for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp_valid <= 1'b0;
      r_cmp_data  <= '0;
      r_cmp_idx   <= '0;
    end else begin
      r_cmp_valid <= w_accept;
      if (w_accept) begin
        r_cmp_data <= i_wr_data;
        r_cmp_idx  <= w_idx;
      end
    end
  end

  // Counter and sticky status flags; first_bad latches only on the first miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_mismatch  <= 1'b0;
      r_first_bad <= '0;
    end else begin
      if (w_accept) begin
        r_count <= r_count + CNT_ONE;
      end
      if (i_wr && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_bad && !r_mismatch) begin
        r_mismatch  <= 1'b1;
        r_first_bad <= r_cmp_idx;
      end
    end
  end

  assign o_rd_q      = r_rd_q;
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_mismatch  = r_mismatch;
  assign o_first_bad = r_first_bad;

endmodule

// File: rtl/output_capture.sv
// Two-channel CPU output capture with expected-value checking and host
// readback. Each channel is an output_channel instance; the top muxes the
// channel RAM read registers onto rd_data and forces zero after reset.
module output_capture
  import hov_io_pkg::*;
#(
  parameter int DATA_W = HOV_DATA_W,
  parameter int ADDR_W = HOV_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr1,
  input  logic              wr2,
  input  logic [DATA_W-1:0] data1_in,
  input  logic [DATA_W-1:0] data2_in,
  input  logic              exp1_write,
  input  logic              exp2_write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count1,
  output logic [ADDR_W:0]   count2,
  output logic              full1,
  output logic              full2,
  output logic              overflow1,
  output logic              overflow2,
  output logic              mismatch1,
  output logic              mismatch2,
  output logic [ADDR_W-1:0] first_bad1,
  output logic [ADDR_W-1:0] first_bad2
);

  logic              w_wr        [HOV_NUM_CH];
  logic [DATA_W-1:0] w_wr_data   [HOV_NUM_CH];
  logic              w_exp_write [HOV_NUM_CH];
  logic [DATA_W-1:0] w_rd_q      [HOV_NUM_CH];
  logic [ADDR_W:0]   w_count     [HOV_NUM_CH];
  logic              w_full      [HOV_NUM_CH];
  logic              w_overflow  [HOV_NUM_CH];
  logic              w_mismatch  [HOV_NUM_CH];
  logic [ADDR_W-1:0] w_first_bad [HOV_NUM_CH];

  ch_sel_e r_rd_sel;
  logic    r_rd_clr;

  assign w_wr[0]        = wr1;
  assign w_wr[1]        = wr2;
  assign w_wr_data[0]   = data1_in;
  assign w_wr_data[1]   = data2_in;
  assign w_exp_write[0] = exp1_write;
  assign w_exp_write[1] = exp2_write;

  genvar gi;
  generate
    for (gi = 0; gi < HOV_NUM_CH; gi++) begin : g_ch
      output_channel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .i_wr        (w_wr[gi]),
        .i_wr_data   (w_wr_data[gi]),
        .i_exp_write (w_exp_write[gi]),
        .i_exp_addr  (addr_in),
        .i_exp_data  (data_in),
        .i_rd_addr   (rd_addr),
        .o_rd_q      (w_rd_q[gi]),
        .o_count     (w_count[gi]),
        .o_full      (w_full[gi]),
        .o_overflow  (w_overflow[gi]),
        .o_mismatch  (w_mismatch[gi]),
        .o_first_bad (w_first_bad[gi])
      );
    end
  endgenerate

  // Track which channel the pending readback belongs to; clear after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_sel <= CH1;
      r_rd_clr <= 1'b1;
    end else begin
      r_rd_sel <= ch_sel_e'(rd_sel);
      r_rd_clr <= 1'b0;
    end
  end

  assign rd_data = r_rd_clr ? '0 : ((r_rd_sel == CH2) ? w_rd_q[1] : w_rd_q[0]);

  assign count1     = w_count[0];
  assign count2     = w_count[1];
  assign full1      = w_full[0];
  assign full2      = w_full[1];
  assign overflow1  = w_overflow[0];
  assign overflow2  = w_overflow[1];
  assign mismatch1  = w_mismatch[0];
  assign mismatch2  = w_mismatch[1];
  assign first_bad1 = w_first_bad[0];
  assign first_bad2 = w_first_bad[1];

endmodule

// File: tb/tb_output_capture.sv
// Self-checking bench for output_capture: directed scenarios plus randomized
// traffic, all compared against a transaction-level model of both channels.
module tb_output_capture;

  localparam int DW    = 12;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr1, wr2;
  logic [DW-1:0] data1_in, data2_in;
  logic          exp1_write, exp2_write;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          rd_sel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count1, count2;
  logic          full1, full2, overflow1, overflow2, mismatch1, mismatch2;
  logic [AW-1:0] first_bad1, first_bad2;

  output_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wr1(wr1), .wr2(wr2), .data1_in(data1_in), .data2_in(data2_in),
    .exp1_write(exp1_write), .exp2_write(exp2_write),
    .addr_in(addr_in), .data_in(data_in),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .count1(count1), .count2(count2), .full1(full1), .full2(full2),
    .overflow1(overflow1), .overflow2(overflow2),
    .mismatch1(mismatch1), .mismatch2(mismatch2),
    .first_bad1(first_bad1), .first_bad2(first_bad2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memories as plain arrays, channel state as integers.
  int unsigned m_exp   [2][DEPTH];
  int unsigned m_cap   [2][DEPTH];
  bit          m_cap_v [2][DEPTH];
  int          m_cnt   [2];
  bit          m_ovf   [2];
  bit          m_mm    [2];
  int          m_fb    [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; wr1 = 0; wr2 = 0; data1_in = '0; data2_in = '0;
    exp1_write = 0; exp2_write = 0; addr_in = '0; data_in = '0;
    rd_sel = 0; rd_addr = '0;
  endtask

  // Apply the current inputs for one clock, update the model, check outputs.
  task automatic cycle();
    int unsigned d[2];
    bit          w[2];
    int unsigned rd_exp;
    bit          rd_chk;
    w[0] = wr1; w[1] = wr2;
    d[0] = 32'(data1_in); d[1] = 32'(data2_in);
    if (rst) begin
      rd_chk = 1; rd_exp = 0;
    end else begin
      rd_chk = m_cap_v[rd_sel][rd_addr];
      rd_exp = m_cap[rd_sel][rd_addr];
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        m_cnt[ch] = 0; m_ovf[ch] = 0; m_mm[ch] = 0; m_fb[ch] = 0;
      end else if (w[ch]) begin
        if (m_cnt[ch] < DEPTH) begin
          if (d[ch] != m_exp[ch][m_cnt[ch]] && !m_mm[ch]) begin
            m_mm[ch] = 1; m_fb[ch] = m_cnt[ch];
          end
          m_cap[ch][m_cnt[ch]]   = d[ch];
          m_cap_v[ch][m_cnt[ch]] = 1;
          m_cnt[ch]++;
        end else begin
          m_ovf[ch] = 1;
        end
      end
    end
    if (exp1_write) m_exp[0][addr_in] = 32'(data_in);
    if (exp2_write) m_exp[1][addr_in] = 32'(data_in);
    @(posedge clk);
    #1;
    check_eq("count1", 32'(count1), m_cnt[0]);
    check_eq("count2", 32'(count2), m_cnt[1]);
    check_eq("full1", 32'(full1), 32'(m_cnt[0] == DEPTH));
    check_eq("full2", 32'(full2), 32'(m_cnt[1] == DEPTH));
    check_eq("overflow1", 32'(overflow1), 32'(m_ovf[0]));
    check_eq("overflow2", 32'(overflow2), 32'(m_ovf[1]));
    if (rd_chk) check_eq("rd_data", 32'(rd_data), rd_exp);
  endtask

  // One quiet cycle lets the comparison results settle, then check them.
  task automatic check_flags();
    idle_inputs();
    cycle();
    check_eq("mismatch1", 32'(mismatch1), 32'(m_mm[0]));
    check_eq("mismatch2", 32'(mismatch2), 32'(m_mm[1]));
    check_eq("first_bad1", 32'(first_bad1), m_fb[0]);
    check_eq("first_bad2", 32'(first_bad2), m_fb[1]);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic load_exp(input int ch, input int addr, input int unsigned val);
    idle_inputs();
    exp1_write = (ch == 0); exp2_write = (ch == 1);
    addr_in = AW'(addr); data_in = DW'(val);
    cycle();
  endtask

  task automatic push(input int ch, input int unsigned val);
    idle_inputs();
    if (ch == 0) begin wr1 = 1; data1_in = DW'(val); end
    else         begin wr2 = 1; data2_in = DW'(val); end
    cycle();
  endtask

  task automatic read_word(input int ch, input int addr);
    idle_inputs();
    rd_sel = ch[0]; rd_addr = AW'(addr);
    cycle();
  endtask

  int unsigned first_word;
  int unsigned last_word;

  initial begin
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
    check_eq("reset_rd_data", 32'(rd_data), 0);
    check_flags();

    // Fill both expected memories so every comparison has a defined target.
    for (int i = 0; i < DEPTH; i++) load_exp(0, i, $urandom_range(0, 4095));
    for (int i = 0; i < DEPTH; i++) load_exp(1, i, $urandom_range(0, 4095));

    // Matching sequence on ch1.
    load_exp(0, 0, 12'h001); load_exp(0, 1, 12'h002); load_exp(0, 2, 12'h003);
    push(0, 12'h001); push(0, 12'h002); push(0, 12'h003);
    check_flags();
    check_eq("s1_count1", 32'(count1), 3);
    check_eq("s1_mismatch1", 32'(mismatch1), 0);

    // Mismatch at index 1; later miss at index 2 must not move first_bad.
    do_reset();
    push(0, 12'h001); push(0, 12'hFFF); push(0, 12'h000);
    check_flags();
    check_eq("s2_mismatch1", 32'(mismatch1), 1);
    check_eq("s2_first_bad1", 32'(first_bad1), 1);
    check_eq("s2_count1", 32'(count1), 3);

    // 257 pushes on ch2: last one dropped, overflow set.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      int unsigned v;
      v = $urandom_range(0, 4095);
      if (i == 0) first_word = v;
      if (i == DEPTH - 1) last_word = v;
      push(1, v);
    end
    check_eq("s3_count2", 32'(count2), 256);
    check_eq("s3_full2", 32'(full2), 1);
    check_eq("s3_overflow2", 32'(overflow2), 1);
    read_word(1, 255);
    check_eq("s3_word255", 32'(rd_data), last_word);
    read_word(1, 0);
    check_eq("s3_word0_kept", 32'(rd_data), first_word);
    check_flags();

    // Same-cycle write and read of index 0 returns the old word.
    do_reset();
    idle_inputs();
    wr1 = 1; data1_in = 12'h0AB; rd_sel = 0; rd_addr = '0;
    cycle();
    check_eq("s4_read_old", 32'(rd_data), 12'h001);
    read_word(0, 0);
    check_eq("s4_read_new", 32'(rd_data), 12'h0AB);

    // Reset mid-push: word in the reset cycle dropped; expected load kept.
    do_reset();
    for (int i = 0; i < 5; i++) load_exp(0, i, 12'h100 + i);
    push(0, 12'h100); push(0, 12'h555); push(0, 12'h102);
    idle_inputs();
    rst = 1; wr1 = 1; data1_in = 12'h103;
    exp1_write = 1; addr_in = '0; data_in = 12'h3C3;
    cycle();
    rst = 0;
    check_flags();
    check_eq("s5_count1_after_rst", 32'(count1), 0);
    check_eq("s5_mismatch1_after_rst", 32'(mismatch1), 0);
    push(0, 12'h3C3);
    for (int i = 1; i < 5; i++) push(0, 12'h100 + i);
    check_flags();
    check_eq("s5_rerun_count1", 32'(count1), 5);
    check_eq("s5_rerun_mismatch1", 32'(mismatch1), 0);

    // Simultaneous wr1, wr2 and exp2 load at index 0.
    do_reset();
    load_exp(0, 0, 12'h0AA);
    load_exp(1, 0, 12'h111);
    idle_inputs();
    wr1 = 1; data1_in = 12'h0AA; wr2 = 1; data2_in = 12'h111;
    exp2_write = 1; addr_in = '0; data_in = 12'h222;
    cycle();
    check_flags();
    check_eq("s6_count1", 32'(count1), 1);
    check_eq("s6_count2", 32'(count2), 1);
    check_eq("s6_mismatch2_old_exp", 32'(mismatch2), 0);
    do_reset();
    push(1, 12'h222);
    check_flags();
    check_eq("s6_new_exp2_stored", 32'(mismatch2), 0);

    // Randomized traffic, mostly matching data so first_bad varies.
    for (int b = 0; b < 4; b++) begin
      do_reset();
      for (int n = 0; n < 450; n++) begin
        idle_inputs();
        wr1 = ($urandom_range(0, 99) < 70);
        wr2 = ($urandom_range(0, 99) < 70);
        data1_in = ($urandom_range(0, 99) < 97) ? DW'(m_exp[0][m_cnt[0] % DEPTH])
                                                : DW'($urandom_range(0, 4095));
        data2_in = ($urandom_range(0, 99) < 97) ? DW'(m_exp[1][m_cnt[1] % DEPTH])
                                                : DW'($urandom_range(0, 4095));
        exp1_write = ($urandom_range(0, 99) < 10);
        exp2_write = ($urandom_range(0, 99) < 10);
        addr_in = AW'($urandom_range(0, DEPTH - 1));
        data_in = DW'($urandom_range(0, 4095));
        rd_sel  = 1'($urandom_range(0, 1));
        rd_addr = AW'($urandom_range(0, DEPTH - 1));
        rst     = ($urandom_range(0, 999) < 3);
        cycle();
        if (n % 50 == 49) check_flags();
      end
      check_flags();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
